// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser.
// Frame: SOF, L, CMD, L-1 payload bytes, EOF.
package uart_cmd_parser_pkg;

   localparam int DATA_W   = 8;
   localparam int NIBBLE_W = 4;

   typedef logic [DATA_W-1:0]   data_t;
   typedef logic [NIBBLE_W-1:0] nibble_t;

   typedef enum logic [7:0] {
      CMD_SET_N  = 8'h01,
      CMD_CLEAR  = 8'h02,
      CMD_LOAD_A = 8'h03,
      CMD_LOAD_B = 8'h04
   } cmd_t;

   localparam data_t SOF = 8'hFE;
   localparam data_t EOF = 8'hEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_CMD,
      ST_PAYLOAD,
      ST_TAIL,
      ST_EXEC
   } state_t;

   // Is L legal for this command? Unknown commands are never legal.
   function automatic logic cmd_len_ok(input data_t cmd, input data_t len);
      logic ok;
      ok = 1'b0;
      case (cmd)
         8'h01:        ok = (len == 8'd2);
         8'h02:        ok = (len == 8'd1);
         8'h03, 8'h04: ok = (len != 8'd0);
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Idle-gap watchdog: counts cycles since the last restart while enabled.
// expired is suppressed when restart is high in the same cycle.
module rx_timeout_counter #(
   parameter int TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || !enable || restart)
         count <= '0;
      else if (!expired)
         count <= count + CW'(1);
   end

   assign expired = enable && !restart && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command decoder feeding the matrix-vector processor.
// All outputs are registered: effects appear one cycle after the byte.
module uart_cmd_parser
   import uart_cmd_parser_pkg::*;
#(
   parameter int DW        = 8,
   parameter int NW        = 4,
   parameter int MAX_N     = 8,
   parameter int DEFAULT_N = 2,
   parameter int TIMEOUT   = 1000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   input  logic          full_A,
   output logic [DW-1:0] uart,
   output logic          push_A,
   output logic          push_B,
   output logic [NW-1:0] N,
   output logic          clear,
   output logic          frame_ok,
   output logic          frame_err
);

   state_t        state, state_nx;
   logic [DW-1:0] len, len_nx;
   cmd_t          cmd, cmd_nx;
   logic [DW-1:0] rem, rem_nx;
   logic [DW-1:0] shadow, shadow_nx;
   logic          ovf, ovf_nx;
   logic [NW-1:0] n_nx;
   logic [DW-1:0] uart_nx;
   logic          push_a_nx, push_b_nx, clear_nx;
   logic          ok_nx, err_nx;
   logic          expired;
   logic          n_legal;

   rx_timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .enable (state != ST_IDLE),
      .restart(rx_valid),
      .expired(expired)
   );

   assign n_legal = (shadow != '0) && (shadow <= DW'(MAX_N));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         len       <= '0;
         cmd       <= CMD_SET_N;
         rem       <= '0;
         shadow    <= '0;
         ovf       <= 1'b0;
         N         <= NW'(DEFAULT_N);
         uart      <= '0;
         push_A    <= 1'b0;
         push_B    <= 1'b0;
         clear     <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         len       <= len_nx;
         cmd       <= cmd_nx;
         rem       <= rem_nx;
         shadow    <= shadow_nx;
         ovf       <= ovf_nx;
         N         <= n_nx;
         uart      <= uart_nx;
         push_A    <= push_a_nx;
         push_B    <= push_b_nx;
         clear     <= clear_nx;
         frame_ok  <= ok_nx;
         frame_err <= err_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      len_nx    = len;
      cmd_nx    = cmd;
      rem_nx    = rem;
      shadow_nx = shadow;
      ovf_nx    = ovf;
      n_nx      = N;
      uart_nx   = uart;
      push_a_nx = 1'b0;
      push_b_nx = 1'b0;
      clear_nx  = 1'b0;
      ok_nx     = 1'b0;
      err_nx    = 1'b0;

      unique case (state)
         // EXEC lasts one cycle; a byte landing there starts the next frame
         ST_IDLE, ST_EXEC: begin
            state_nx = ST_IDLE;
            if (rx_valid && rx_data == SOF) begin
               state_nx = ST_LEN;
               ovf_nx   = 1'b0;
            end
         end
         ST_LEN: if (rx_valid) begin
            if (rx_data == '0) begin
               err_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               len_nx   = rx_data;
               state_nx = ST_CMD;
            end
         end
         ST_CMD: if (rx_valid) begin
            cmd_nx = cmd_t'(rx_data);
            if (!cmd_len_ok(rx_data, len)) begin
               err_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else if (len == DW'(1)) begin
               state_nx = ST_TAIL;
            end else begin
               rem_nx   = len - DW'(1);
               state_nx = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: if (rx_valid) begin
            rem_nx = rem - DW'(1);
            if (rem == DW'(1))
               state_nx = ST_TAIL;
            case (cmd)
               CMD_LOAD_A: begin
                  if (full_A) begin
                     ovf_nx = 1'b1;
                  end else begin
                     push_a_nx = 1'b1;
                     uart_nx   = rx_data;
                  end
               end
               CMD_LOAD_B: begin
                  push_b_nx = 1'b1;
                  uart_nx   = rx_data;
               end
               CMD_SET_N: shadow_nx = rx_data;
               default: ;
            endcase
         end
         ST_TAIL: if (rx_valid) begin
            if (rx_data != EOF) begin
               err_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_EXEC;
               case (cmd)
                  CMD_SET_N: begin
                     if (n_legal) begin
                        n_nx  = shadow[NW-1:0];
                        ok_nx = 1'b1;
                     end else begin
                        err_nx = 1'b1;
                     end
                  end
                  CMD_CLEAR: begin
                     clear_nx = 1'b1;
                     ok_nx    = 1'b1;
                  end
                  default: begin
                     ok_nx  = !ovf;
                     err_nx = ovf;
                  end
               endcase
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      // A byte in the expiry cycle wins, so only a silent gap aborts
      if (!rx_valid && expired && state != ST_IDLE && state != ST_EXEC) begin
         err_nx   = 1'b1;
         state_nx = ST_IDLE;
      end
   end

endmodule
